// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: the controller
// state encoding and the default operand width.
package serial_adder_pkg;

    // Default operand/result width; legal range is 2..32.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// Single 1-bit full-adder cell. Purely combinational; the serial controller
// time-shares one instance across all operand bits.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic s
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        s    = x ^ y ^ cin;
        cout = (x & y) | (x & cin) | (y & cin);
    end

endmodule : full_adder_bit

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Adds two WIDTH-bit operands plus carry-in
// one bit per clock, LSB first, through a single shared full-adder cell.
// Handshake: start (accepted in IDLE or DONE), busy (RUN), done (1 cycle).
// Optional build macro SERIAL_ADDER_OVF_EN adds the signed overflow output
// ovf, captured together with cout on the final RUN edge.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    // The one shared full-adder cell works on the current LSBs and carry.
    full_adder_bit u_fa (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .cin  (carry_q),
        .cout (fa_cout),
        .s    (fa_s)
    );

    // A new start is taken only when not already running; start in RUN is dropped.
    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_bit = (cnt_q == CNT_LAST);

    // Next-state, shift-path and handshake computation.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        if (accept) begin
            // Capture operands; sum is left alone so it only changes by shifting.
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    carry_d = fa_cout;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        state_d = ST_DONE;
                        cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into the MSB is the carry entering this last cell.
                        ovf_d   = carry_q ^ fa_cout;
`endif
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Handshake outputs are registered, decoded from the state being entered.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Controller state, datapath registers and registered outputs.
    always_ff @(posedge ck or negedge rst_n) begin
        // NOTE: all state, operand registers included, is reset so no partial result survives.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a WIDTH=8 instance for the
// directed, random, back-to-back and reset cases, and a WIDTH=2 instance
// for the exhaustive sweep. Expected results come from plain arithmetic.
module tb_serial_adder_ctrl;

    logic       ck;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .ck    (ck),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .ck    (ck),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf2)
`endif
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: the true signed sum does not fit in 8 bits.
    function automatic logic ovf_ref(input logic [7:0] x, input logic [7:0] y, input logic c);
        int sx, sy, s;
        sx = int'($signed(x));
        sy = int'($signed(y));
        s  = sx + sy + (c ? 1 : 0);
        return (s > 127) || (s < -128);
    endfunction
`endif

    // One WIDTH=8 addition from IDLE. With poke set, start is re-asserted
    // mid-run with different operands, which must have no effect.
    task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        input bit poke, input string tag);
        logic [8:0] exp_full;
        logic [8:0] got;
        logic       got_ovf;
        int         busy_n, done_n, done_at;
        exp_full = 9'(av) + 9'(bv) + 9'(ci);
        got      = 'x;
        got_ovf  = 1'bx;
        busy_n   = 0;
        done_n   = 0;
        done_at  = -1;
        a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
        @(posedge ck); #1;
        start8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                done_at = i;
                got     = {cout8, sum8};
`ifdef SERIAL_ADDER_OVF_EN
                got_ovf = ovf8;
`endif
            end
            if (poke) begin
                start8 = (i == 2);
                a8     = ~av;
                b8     = 8'h33;
                cin8   = ~ci;
            end
            @(posedge ck); #1;
        end
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd8);
        check({tag, "_done_pulses"}, 64'(done_n), 64'd1);
        check({tag, "_done_timing"}, 64'(done_at), 64'd8);
        check({tag, "_result"}, 64'(got), 64'(exp_full));
        check({tag, "_held"}, 64'({cout8, sum8}), 64'(exp_full));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 64'(got_ovf), 64'(ovf_ref(av, bv, ci)));
        check({tag, "_ovf_held"}, 64'(ovf8), 64'(ovf_ref(av, bv, ci)));
`endif
    endtask

    initial begin
        logic [7:0] qa [3];
        logic [7:0] qb [3];
        logic       qc [3];
        int         k, last_done;
        logic [2:0] got2;
        logic [1:0] av2, bv2;
        logic       ci2;
        logic [4:0] v5;

        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

        // Reset state.
        repeat (2) @(posedge ck);
        #1;
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_sum", 64'(sum8), 64'd0);
        check("rst_cout", 64'(cout8), 64'd0);
        rst_n = 1'b1;
        @(posedge ck); #1;

        // Directed cases.
        add8(8'h3C, 8'h0F, 1'b0, 1'b0, "add_3c_0f");
        add8(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c1");
        add8(8'h01, 8'h01, 1'b0, 1'b1, "start_ignored");
        add8(8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01");
        add8(8'h80, 8'hFF, 1'b0, 1'b0, "add_80_ff");
        add8(8'h10, 8'h20, 1'b0, 1'b0, "add_10_20");

        // Random cases.
        for (int r = 0; r < 6; r++)
            add8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rand");

        // Back-to-back: start held high through DONE chains three additions.
        for (int i = 0; i < 3; i++) begin
            qa[i] = 8'($urandom);
            qb[i] = 8'($urandom);
            qc[i] = 1'($urandom);
        end
        a8 = qa[0]; b8 = qb[0]; cin8 = qc[0]; start8 = 1'b1;
        @(posedge ck); #1;
        k = 0;
        last_done = -1;
        for (int c = 0; c < 40; c++) begin
            if (done8) begin
                if (k < 3)
                    check("b2b_result", 64'({cout8, sum8}),
                          64'(9'(qa[k]) + 9'(qb[k]) + 9'(qc[k])));
                if (last_done >= 0)
                    check("b2b_period", 64'(c - last_done), 64'd9);
                last_done = c;
                k++;
                if (k < 3) begin
                    a8 = qa[k]; b8 = qb[k]; cin8 = qc[k];
                end else begin
                    start8 = 1'b0;
                end
            end
            @(posedge ck); #1;
        end
        check("b2b_count", 64'(k), 64'd3);

        // Reset in the middle of a run, after a result with cout=1.
        add8(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        @(posedge ck); #1;
        start8 = 1'b0;
        repeat (4) @(posedge ck);
        #3;
        check("mid_busy_before", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy8), 64'd0);
        check("mid_rst_done", 64'(done8), 64'd0);
        check("mid_rst_sum", 64'(sum8), 64'd0);
        check("mid_rst_cout", 64'(cout8), 64'd0);
        #2;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge ck); #1;
            check("post_rst_idle", 64'({busy8, done8}), 64'd0);
        end
        add8(8'h5A, 8'hA7, 1'b1, 1'b0, "post_rst_add");

        // WIDTH=2 exhaustive sweep over {cin,a,b}.
        for (int v = 0; v < 32; v++) begin
            v5 = 5'(v);
            ci2 = v5[4];
            av2 = v5[3:2];
            bv2 = v5[1:0];
            a2 = av2; b2 = bv2; cin2 = ci2; start2 = 1'b1;
            @(posedge ck); #1;
            start2 = 1'b0;
            got2 = 'x;
            for (int c = 0; c < 5; c++) begin
                if (done2) got2 = {cout2, sum2};
                @(posedge ck); #1;
            end
            check("w2_sweep", 64'(got2), 64'(3'(av2) + 3'(bv2) + 3'(ci2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_adder_ctrl

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It time-shares a single 1-bit full-adder cell to add two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It holds the carry flip-flop, bit counter and result shift register, and presents a start/busy/done handshake to the surrounding datapath. It is the sequencing wrapper the lab designs use around the full-adder cell.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
ck  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  request; sampled on rising ck when controller can accept
a  input  WIDTH  operand A, captured with accepted start
b  input  WIDTH  operand B, captured with accepted start
cin  input  1  carry-in, captured with accepted start
busy  output  1  high while an addition is in progress (RUN state)
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result bits, held until next accepted start
cout  output  1  final carry-out, held with sum

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand registers, carry and counter cleared.
  - Release is synchronous to the next ck edge; no partial result is ever reported.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 at an edge: capture a, b, cin into shift registers, carry<=cin, count<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), each edge:
  - The full-adder cell computes from A[0], B[0] and carry.
  - Sum bit shifts into sum MSB; the sum register shifts right.
  - A and B shift right; carry<=cell carry-out; count<=count+1.
  - When count==WIDTH-1, go to DONE; cout<=final carry.
  - start during RUN is ignored; no queueing.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Next state is RUN if start=1 (new operands captured, back-to-back operation), else IDLE.
- Latency:
  - start sampled at edge E; busy high from E.
  - The last bit is computed on edge E+WIDTH; done is high during the cycle after edge E+WIDTH.
  - Result is valid at edge E+WIDTH+1.
  - Throughput is one addition per WIDTH+1 cycles.
- sum/cout:
  - Update only through the shift path.
  - Stable from done until the next accepted start. After that, sum contents are don't-care, but cout holds its old value until the next DONE.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); unsigned.
- Counter width: $clog2(WIDTH) bits; wrap not used (exit is at WIDTH-1).

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output ovf (1 bit): signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - Captured on the final RUN edge, same timing and hold rules as cout; reset 0.
- Undefined: port absent, no extra logic.

Decomposition:
- Package serial_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH localparam.
- One sub-module, full_adder_bit (x, y, cin -> cout, s; purely combinational), instantiated once.
- Controller, shift registers and counter stay in serial_adder_ctrl.

Test Plan:
- WIDTH=8: a=0x3C, b=0x0F, cin=0, start one cycle.
  - Required: busy 8 cycles, done pulse exactly once, sum=0x4B, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Busy and back-to-back handling:
  - start pulsed with a=0x01, b=0x01, cin=0; start re-asserted at cycle 3 during RUN with other operands -> ignored; result sum=0x02.
  - start held high in DONE -> new operation begins, done pulses every 9 cycles.
- Reset mid-operation:
  - rst_n low at cycle 4 of RUN -> immediately busy=0, done=0, sum=0, cout=0.
  - After release the controller is IDLE; a fresh start gives a correct result.
- WIDTH=2 exhaustive sweep over all 32 {cin,a,b} -> {cout,sum}==a+b+cin every case.
  - With SERIAL_ADDER_OVF_EN, WIDTH=8: 0x7F+0x01 -> ovf=1; 0x80+0xFF -> ovf=1, cout=1; 0x10+0x20 -> ovf=0.
